clock_div: RTL
==============

CLOCK_DIV -- requirements
Module: clock_div

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent divided-clock channels (1..16).
REQ-002 Parameter WIDTH, default 16: width of each channel's half-period divisor and counter.
REQ-003 Parameter RESET_DIV, default 2: divisor loaded into every channel at reset.
REQ-004 Parameter CW (derived), default max(1, clog2(CHANNELS)): LOAD_CH width.
REQ-005 CLK  in  1  single clock; all state updates on its rising edge.
REQ-006 RST_N  in  1  asynchronous, active-low reset.
REQ-007 ENABLE  in  1  global run; high = channels count, low = channels frozen.
REQ-008 LOAD_VALID  in  1  divisor-load request.
REQ-009 LOAD_READY  out  1  load accepted on an edge where LOAD_VALID and LOAD_READY are both high.
REQ-010 LOAD_CH  in  CW  target channel index for the load.
REQ-011 LOAD_DIV  in  WIDTH  new half-period divisor D.
REQ-012 CLK_OUT  out  CHANNELS  registered divided square wave, one bit per channel.
REQ-013 TICK  out  CHANNELS  registered one-cycle pulse per channel, high in the cycle CLK_OUT bit goes 0->1.
REQ-014 STEP  in  1  single-step request; port present only with CLOCK_DIV_STEP_EN.

Function
REQ-015 Each channel SHALL hold divisor D[i] and counter C[i]; when advancing and D[i]>0, C[i] increments, and when C[i]==D[i]-1 it SHALL wrap to 0 and toggle CLK_OUT[i].
REQ-016 CLK_OUT[i] period SHALL be exactly 2*D[i] CLK cycles; the first rise after reset SHALL occur on the D[i]-th advancing edge.
REQ-017 Channels SHALL advance on every edge with ENABLE=1; with ENABLE=0, C, CLK_OUT hold and TICK=0.
REQ-018 D[i]==0 SHALL stop channel i: CLK_OUT[i]=0, C[i]=0, TICK[i]=0.
REQ-019 Load FSM states: IDLE, PENDING; LOAD_READY SHALL equal (state==IDLE), combinationally.
REQ-020 IDLE->PENDING on accepted load; LOAD_CH and LOAD_DIV SHALL be captured into shadow registers.
REQ-021 LOAD_CH >= CHANNELS SHALL be accepted and discarded: FSM stays IDLE, no channel state changes.
REQ-022 PENDING apply: on the edge where the target channel wraps (REQ-015), D <= shadow, C <= 0, toggle proceeds normally; a new D of 0 forces CLK_OUT=0 instead of toggling.
REQ-023 If the target channel is stopped (D==0) or ENABLE=0, apply SHALL occur on the first edge after acceptance, with C <= 0 and CLK_OUT unchanged (forced 0 if new D==0).
REQ-024 PENDING->IDLE on the apply edge; apply never occurs on the acceptance edge; minimum LOAD_READY-low time is 1 cycle.
REQ-025 Non-target channels SHALL be unaffected by any load.
REQ-026 Counter compare SHALL be WIDTH-bit unsigned; D = 2^WIDTH-1 is legal.

Reset
REQ-027 RST_N low SHALL immediately set C=0, CLK_OUT=0, TICK=0, D[i]=RESET_DIV, FSM=IDLE (LOAD_READY=1), and discard any pending load.
REQ-028 First counting edge SHALL be the first rising CLK after RST_N deasserts.

Configuration
REQ-029 With CLOCK_DIV_STEP_EN defined, STEP exists; when ENABLE=0 and STEP=1, all channels SHALL advance exactly one count on that edge (TICK and apply rules as REQ-015/022); STEP is ignored when ENABLE=1.
REQ-030 Without CLOCK_DIV_STEP_EN, the STEP port SHALL be absent and ENABLE=0 always freezes all channels.

Verification (bench CHANNELS=3, WIDTH=8, RESET_DIV=2)
REQ-031 Release reset, ENABLE=1 -> CLK_OUT[0..2] rise on edges 2, 6, 10, fall on 4, 8; TICK pulses on edges 2, 6, 10 only.
REQ-032 Load CH=1, D=5 mid-period -> LOAD_READY low next cycle; new D applied at ch1's next toggle; following half-periods 5 cycles; LOAD_READY high the cycle after apply; ch0, ch2 unchanged.
REQ-033 Load CH=2, D=0 -> CLK_OUT[2] forced 0 at its next wrap, stays 0, no TICK[2]; then load D=3 -> applied next edge, first rise 3 cycles later.
REQ-034 ENABLE low for 7 cycles with C[0]=1 -> outputs frozen, TICK=0; after re-enable, next toggle after 1 cycle.
REQ-035 Load CH=3 -> accepted, LOAD_READY stays high, no channel changes; RST_N pulsed while PENDING -> pending divisor lost, all D=2.
REQ-036 (CLOCK_DIV_STEP_EN) ENABLE=0, four STEP pulses from reset -> CLK_OUT rises on 2nd, falls on 4th; TICK only on the 2nd.

Source files
------------

// File: rtl/clock_div.sv
// rtl/clock_div.sv - multi-channel programmable clock divider with deferred divisor loads
// Optional single-step input: define CLOCK_DIV_STEP_EN.
module clock_div #(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 16,
    parameter int RESET_DIV = 2,
    parameter int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [CW-1:0]       load_ch,
    input  logic [WIDTH-1:0]    load_div,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
`ifdef CLOCK_DIV_STEP_EN
    ,
    input  logic                step
`endif
);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    localparam logic [CW:0] CH_LIMIT = (CW + 1)'(CHANNELS);

    state_t               state_q;
    state_t               state_d;
    logic [CW-1:0]        shadow_ch;
    logic [WIDTH-1:0]     shadow_div;
    logic                 advance;
    logic                 ch_ok;
    logic                 accept;
    logic [CHANNELS-1:0]  apply_vec;

`ifdef CLOCK_DIV_STEP_EN
    // A step only matters while the channels are otherwise frozen.
    assign advance = enable | step;
`else
    assign advance = enable;
`endif

    assign ch_ok  = ({1'b0, load_ch} < CH_LIMIT);
    assign accept = load_valid && (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        load_ready = (state_q == IDLE);
        case (state_q)
            IDLE:    if (load_valid && ch_ok) state_d = PENDING;
            PENDING: if (|apply_vec) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shadow_ch  <= '0;
            shadow_div <= '0;
        end else begin
            state_q <= state_d;
            if (accept && ch_ok) begin
                shadow_ch  <= load_ch;
                shadow_div <= load_div;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] div_r;
        logic [WIDTH-1:0] cnt_r;
        logic             out_r;
        logic             tick_r;
        logic             is_target;
        logic             wraps;
        logic             apply;

        assign is_target = (state_q == PENDING) && (shadow_ch == CW'(i));
        assign wraps     = advance && (div_r != '0) && (cnt_r == div_r - WIDTH'(1));
        // A stopped or frozen target would never wrap, so it takes the new divisor at once.
        assign apply     = is_target && ((div_r == '0) || !advance || wraps);
        assign apply_vec[i] = apply;
        assign clk_out[i]   = out_r;
        assign tick[i]      = tick_r;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                div_r  <= WIDTH'(RESET_DIV);
                cnt_r  <= '0;
                out_r  <= 1'b0;
                tick_r <= 1'b0;
            end else if (apply) begin
                div_r <= shadow_div;
                cnt_r <= '0;
                if (shadow_div == '0) begin
                    out_r  <= 1'b0;
                    tick_r <= 1'b0;
                end else if (wraps) begin
                    out_r  <= ~out_r;
                    tick_r <= ~out_r;
                end else begin
                    tick_r <= 1'b0;
                end
            end else if (div_r == '0) begin
                cnt_r  <= '0;
                out_r  <= 1'b0;
                tick_r <= 1'b0;
            end else if (wraps) begin
                cnt_r  <= '0;
                out_r  <= ~out_r;
                tick_r <= ~out_r;
            end else if (advance) begin
                cnt_r  <= cnt_r + WIDTH'(1);
                tick_r <= 1'b0;
            end else begin
                tick_r <= 1'b0;
            end
        end
    end

endmodule
